sc_stream_accumulator: RTL and testbench

Downstream stage of the canonical-form stochastic circuit: consumes its `outputs` bitstreams one sample per cycle and converts each of `NUM_OUTPUTS` unipolar streams back to a binary value. It counts ones over a fixed window of 2^LOG_LEN accepted samples, then presents all counts at once through a valid/ready result port. A one-deep result buffer lets the next window accumulate while the previous result waits. Back-pressure stalls the input side only when a completed window cannot be unloaded.

---
 rtl/sc_pkg.sv | 17 +
 rtl/sc_bit_counter.sv | 38 +++
 rtl/sc_stream_accumulator.sv | 123 ++++++++++++
 tb/tb_sc_stream_accumulator.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-stream accumulator.
// Contents: accumulator FSM state encoding and the ones-count width helper.
// No ports; imported by sc_bit_counter and sc_stream_accumulator.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FULL  = 2'd2
    } acc_state_t;

    // One extra bit so an all-ones window of 2^log_len samples does not wrap.
    function automatic int cnt_w(input int log_len);
        return log_len + 1;
    endfunction

endpackage

// File: rtl/sc_bit_counter.sv
// Ones counter for a single unipolar bitstream.
// Ports: clk/rst (async active-high), clr (synchronous clear), en (sample accepted),
//        bit_in (stream bit), count (registered ones-count, CW bits).
module sc_bit_counter #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q, count_d;

    // Clear wins over increment: the completing sample has already been
    // folded into the result path by the top level when both are asserted.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && bit_in) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sc_stream_accumulator.sv
// Converts NUM_OUTPUTS unipolar bitstreams to binary ones-counts over 2^LOG_LEN-sample windows.
// Ports: clk/rst, start/continuous control, in_valid/in_ready/bits sample input,
//        busy status, out_valid/out_ready/counts result output (stream i at [i*(LOG_LEN+1) +: LOG_LEN+1]).
module sc_stream_accumulator
    import sc_pkg::*;
#(
    parameter int NUM_OUTPUTS = 1,
    parameter int LOG_LEN     = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   continuous,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_OUTPUTS-1:0]                 bits,
    output logic                                   busy,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUM_OUTPUTS*cnt_w(LOG_LEN)-1:0]  counts
);

    localparam int CW = cnt_w(LOG_LEN);
    localparam int TW = NUM_OUTPUTS * CW;

    acc_state_t          state_q, state_d;
    logic [LOG_LEN-1:0]  idx_q, idx_d;
    logic [TW-1:0]       counts_q, counts_d;
    logic                out_valid_q, out_valid_d;
    logic [TW-1:0]       work_cnt;
    logic [TW-1:0]       final_cnt;
    logic                cnt_clr;
    logic                cnt_en;

    // Working counters; final_cnt includes the sample presented this cycle so
    // a completing window can be unloaded without an extra cycle.
    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_cnt
        sc_bit_counter #(.CW(CW)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .clr    (cnt_clr),
            .en     (cnt_en),
            .bit_in (bits[i]),
            .count  (work_cnt[i*CW +: CW])
        );
        assign final_cnt[i*CW +: CW] = work_cnt[i*CW +: CW] + CW'(bits[i]);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        counts_d    = counts_q;
        out_valid_d = out_valid_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        // Consume; a load below in the same cycle overrides this.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    cnt_en = 1'b1;
                    // Index wraps to zero on the completing sample.
                    idx_d  = idx_q + LOG_LEN'(1);
                    if (&idx_q) begin
                        if (!out_valid_q || out_ready) begin
                            counts_d    = final_cnt;
                            out_valid_d = 1'b1;
                            cnt_clr     = 1'b1;
                            state_d     = continuous ? ACCUM : IDLE;
                        end else begin
                            // Buffer occupied: the increment above leaves the
                            // final counts parked in the working counters.
                            state_d = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    counts_d    = work_cnt;
                    out_valid_d = 1'b1;
                    cnt_clr     = 1'b1;
                    idx_d       = '0;
                    state_d     = continuous ? ACCUM : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            counts_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            counts_q    <= counts_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign counts    = counts_q;

endmodule

// File: tb/tb_sc_stream_accumulator.sv
module tb_sc_stream_accumulator;

    localparam int N  = 2;
    localparam int L  = 3;
    localparam int CW = L + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          continuous;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  bits;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [N*CW-1:0] counts;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sc_stream_accumulator #(.NUM_OUTPUTS(N), .LOG_LEN(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bits       (bits),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .counts     (counts)
    );

    typedef struct {
        logic       st;
        logic       vld;
        logic [1:0] b;
        logic       ordy;
        logic       e_rdy;
        logic       e_ov;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are checked there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0; continuous = 1'b0; in_valid = 1'b0; bits = '0; out_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin : main
        int acc;
        int results;
        logic [3:0] e0, e1;

        // Basic window: stream0 all ones, stream1 10101010.
        vecs[0] = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00};
        for (int k = 1; k <= 8; k++) begin
            vecs[k] = '{1'b0, 1'b1, {((k % 2) == 1), 1'b1}, 1'b1, 1'b1, 1'b0, 8'h00};
        end
        vecs[9]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h48};
        vecs[10] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h48};

        // 1: reset and idle with in_valid high
        do_reset();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; bits = 2'b11;
            check("t1_in_ready", 32'(in_ready), 32'd0);
            check("t1_busy", 32'(busy), 32'd0);
            check("t1_out_valid", 32'(out_valid), 32'd0);
            check("t1_counts", 32'(counts), 32'd0);
            step();
        end

        // 2: table-driven basic window
        do_reset();
        for (int k = 0; k < 11; k++) begin
            start = vecs[k].st; in_valid = vecs[k].vld; bits = vecs[k].b; out_ready = vecs[k].ordy;
            check($sformatf("t2_rdy[%0d]", k), 32'(in_ready), 32'(vecs[k].e_rdy));
            check($sformatf("t2_ov[%0d]", k), 32'(out_valid), 32'(vecs[k].e_ov));
            check($sformatf("t2_cnt[%0d]", k), 32'(counts), 32'(vecs[k].e_cnt));
            step();
        end
        check("t2_busy_idle", 32'(busy), 32'd0);

        // 3: continuous back-to-back, consumer always ready
        do_reset();
        continuous = 1'b1; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        results = 0;
        for (int k = 0; k < 24; k++) begin
            in_valid = 1'b1; bits = {1'b0, ((k % 2) == 0)};
            check("t3_in_ready", 32'(in_ready), 32'd1);
            if (out_valid) begin
                results++;
                check("t3_counts", 32'(counts), 32'h04);
            end
            step();
        end
        in_valid = 1'b0;
        if (out_valid) begin
            results++;
            check("t3_counts_last", 32'(counts), 32'h04);
        end
        check("t3_results", 32'(results), 32'd3);

        // 4: back-pressure into FULL, then one-cycle release
        do_reset();
        continuous = 1'b1; out_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            bits = (acc < 8) ? 2'b01 : 2'b10;
            check("t4_in_ready", 32'(in_ready), (acc < 16) ? 32'd1 : 32'd0);
            if (acc < 16) acc++;
            step();
        end
        in_valid = 1'b0;
        check("t4_full_ov", 32'(out_valid), 32'd1);
        check("t4_full_cnt", 32'(counts), 32'h08);
        check("t4_full_rdy", 32'(in_ready), 32'd0);
        check("t4_full_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t4_rel_cnt", 32'(counts), 32'h80);
        check("t4_rel_ov", 32'(out_valid), 32'd1);
        check("t4_rel_rdy", 32'(in_ready), 32'd1);

        // 5: random input gaps, start pulsed mid-window
        do_reset();
        continuous = 1'b0; out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        acc = 0; e0 = '0; e1 = '0;
        for (int k = 0; k < 100 && acc < 8; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            bits = 2'($urandom);
            start = (k == 4) || (k == 9);
            check("t5_in_ready", 32'(in_ready), 32'd1);
            check("t5_ov_early", 32'(out_valid), 32'd0);
            if (in_valid) begin
                acc++;
                e0 = e0 + 4'(bits[0]);
                e1 = e1 + 4'(bits[1]);
            end
            step();
        end
        start = 1'b0; in_valid = 1'b0;
        check("t5_accepted", 32'(acc), 32'd8);
        check("t5_ov", 32'(out_valid), 32'd1);
        check("t5_counts", 32'(counts), 32'({e1, e0}));
        check("t5_idle", 32'(busy), 32'd0);

        // 6: reset mid-window discards partial data
        do_reset();
        out_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; bits = 2'b11;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_ov", 32'(out_valid), 32'd0);
        check("t6_rst_rdy", 32'(in_ready), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_cnt", 32'(counts), 32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; bits = (k < 3) ? 2'b01 : 2'b00;
            step();
        end
        in_valid = 1'b0;
        check("t6_ov", 32'(out_valid), 32'd1);
        check("t6_counts", 32'(counts), 32'h03);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
